// File: rtl/clkdiv_ctrl.sv
// Programmable clock-enable divider: clk_out square wave plus clk_en on each rising edge.
// Latency: first rising edge 1 cycle after run; divisor changes take effect at the end of a low phase.
// Backpressure: 4-phase div_req/div_ack; the ack is withheld until the new divisor is in effect.
module clkdiv_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_req,
    output logic             div_ack,
    output logic             clk_out,
    output logic             clk_en,
    output logic             running,
    output logic [WIDTH-1:0] cur_div
);

    typedef enum logic [1:0] {STOP, RUN, PEND, ACKW} state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV / 2 - 1);

    function automatic logic [WIDTH-1:0] sanitise(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] n;
        n = {d[WIDTH-1:1], 1'b0};
        if (n < WIDTH'(2)) n = WIDTH'(2);
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] half_m1(input logic [WIDTH-1:0] d);
        return (d >> 1) - WIDTH'(1);
    endfunction

    state_t           state, state_d;
    logic [WIDTH-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] cur_div_d, pend_div, pend_div_d;
    logic             clk_out_d, clk_en_d, div_ack_d, running_d;
    logic [WIDTH-1:0] req_div;
    logic             new_req, boundary;
    logic             apply_en;
    logic [WIDTH-1:0] apply_div;

    assign req_div  = sanitise(div_in);
    assign new_req  = div_req & ~div_ack;
    // End of the low phase: the only point where rate or run state may change.
    assign boundary = running & (cnt == '0) & ~clk_out;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        clk_out_d  = clk_out;
        clk_en_d   = 1'b0;
        div_ack_d  = div_ack;
        running_d  = running;
        cur_div_d  = cur_div;
        pend_div_d = pend_div;
        apply_en   = 1'b0;
        apply_div  = pend_div;

        if (running) begin
            if (cnt == '0) begin
                cnt_d = half_m1(cur_div);
                if (clk_out) begin
                    clk_out_d = 1'b0;
                end else if (run) begin
                    clk_out_d = 1'b1;
                    clk_en_d  = 1'b1;
                end else begin
                    running_d = 1'b0;
                end
            end else begin
                cnt_d = cnt - WIDTH'(1);
            end
        end else begin
            cnt_d = half_m1(cur_div);
        end

        case (state)
            STOP: begin
                if (new_req) begin
                    apply_en  = 1'b1;
                    apply_div = req_div;
                end else if (run) begin
                    clk_out_d = 1'b1;
                    clk_en_d  = 1'b1;
                    running_d = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (new_req) begin
                    // A request landing exactly on a boundary is applied there rather than a period later.
                    if (boundary) begin
                        apply_en  = 1'b1;
                        apply_div = req_div;
                    end else begin
                        pend_div_d = req_div;
                        state_d    = PEND;
                    end
                end else if (!running_d) begin
                    state_d = STOP;
                end
            end
            PEND: begin
                if (boundary) apply_en = 1'b1;
            end
            ACKW: begin
                if (!div_req) begin
                    div_ack_d = 1'b0;
                    state_d   = running_d ? RUN : STOP;
                end
            end
            default: state_d = STOP;
        endcase

        if (apply_en) begin
            cur_div_d = apply_div;
            cnt_d     = half_m1(apply_div);
            div_ack_d = 1'b1;
            state_d   = ACKW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STOP;
            cnt      <= DEF_CNT;
            clk_out  <= 1'b0;
            clk_en   <= 1'b0;
            div_ack  <= 1'b0;
            running  <= 1'b0;
            cur_div  <= DEF_DIV;
            pend_div <= DEF_DIV;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            clk_out  <= clk_out_d;
            clk_en   <= clk_en_d;
            div_ack  <= div_ack_d;
            running  <= running_d;
            cur_div  <= cur_div_d;
            pend_div <= pend_div_d;
        end
    end

endmodule
